// File: rtl/title_sequencer_pkg.sv
// Shared definitions for the title-overlay sequencer and its neighbours:
// FSM state encoding and the default display timing constants.
package title_sequencer_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ARM   = 2'd1;
  localparam state_t ST_SHOW  = 2'd2;
  localparam state_t ST_BLINK = 2'd3;

  // Default overlay timing, shared with the other overlay blocks.
  localparam int DEF_NUM_TITLES    = 4;
  localparam int DEF_SHOW_FRAMES   = 60;
  localparam int DEF_BLINK_FRAMES  = 15;
  localparam int DEF_BLINK_TOGGLES = 4;
  localparam int DEF_CNT_W         = 8;

endpackage

// File: rtl/title_sequencer_if.sv
// Control bundle between the overlay controller (master) and the title
// sequencer (slave): frame timing, requests, abort, and region enables.
interface title_sequencer_if #(
  parameter int NUM_TITLES = 4
) ();

  localparam int ID_W = $clog2(NUM_TITLES);

  logic                  frame_start;
  logic [NUM_TITLES-1:0] req;
  logic                  force_off;
  logic [NUM_TITLES-1:0] title_en;
  logic [ID_W-1:0]       grant_id;
  logic                  busy;
  logic                  done;

  modport master (
    output frame_start, req, force_off,
    input  title_en, grant_id, busy, done
  );

  modport slave (
    input  frame_start, req, force_off,
    output title_en, grant_id, busy, done
  );

endinterface

// File: rtl/title_sequencer_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above i_ptr,
// wrapping at N. Reusable for any shared overlay resource.
module rr_arbiter #(
  parameter  int N     = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_idx
);

  logic [IDX_W-1:0] w_pos;

  // Scan offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    // NOTE: every output gets a default before the loop, so no path leaves
    // a value unassigned and no latch is inferred.
    o_valid = 1'b0;
    o_idx   = '0;
    w_pos   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_pos = IDX_W'((int'(i_ptr) + k) % N);
      if (i_req[w_pos]) begin
        o_valid = 1'b1;
        o_idx   = w_pos;
      end
    end
  end

endmodule

// File: rtl/title_sequencer.sv
// Frame-synchronous title scheduler: grants one requester round-robin,
// lights its region for SHOW_FRAMES frames, then blinks it, changing
// enables only on frame boundaries.
module title_sequencer
  import title_sequencer_pkg::*;
#(
  parameter int NUM_TITLES    = DEF_NUM_TITLES,
  parameter int SHOW_FRAMES   = DEF_SHOW_FRAMES,
  parameter int BLINK_FRAMES  = DEF_BLINK_FRAMES,
  parameter int BLINK_TOGGLES = DEF_BLINK_TOGGLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  title_sequencer_if.slave   bus
);

  localparam int ID_W = $clog2(NUM_TITLES);
  localparam int BC_W = (BLINK_TOGGLES < 2) ? 1 : $clog2(BLINK_TOGGLES + 1);

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_FRAMES - 1);
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);
  localparam logic [BC_W-1:0]  BLINK_END  = BC_W'(BLINK_TOGGLES);

  state_t                r_state;
  logic [NUM_TITLES-1:0] r_title_en;
  logic [ID_W-1:0]       r_grant_id;
  logic [ID_W-1:0]       r_rr_ptr;
  logic                  r_busy;
  logic                  r_done;
  logic [CNT_W-1:0]      r_frame_cnt;
  logic [BC_W-1:0]       r_blink_cnt;

  logic                  w_arb_valid;
  logic [ID_W-1:0]       w_arb_idx;
  logic [NUM_TITLES-1:0] w_grant_oh;
  logic [ID_W-1:0]       w_next_ptr;
  logic                  w_show_end;
  logic                  w_blink_end;
  logic                  w_finish;

  rr_arbiter #(.N(NUM_TITLES)) u_arb (
    .i_req   (bus.req),
    .i_ptr   (r_rr_ptr),
    .o_valid (w_arb_valid),
    .o_idx   (w_arb_idx)
  );

  // One-hot enable pattern of the granted title.
  always_comb begin
    w_grant_oh             = '0;
    w_grant_oh[r_grant_id] = 1'b1;
  end

  // Frame-boundary events that end a phase, and the normal-completion point.
  assign w_show_end  = (r_state == ST_SHOW)  && bus.frame_start && (r_frame_cnt == SHOW_LAST);
  assign w_blink_end = (r_state == ST_BLINK) && bus.frame_start && (r_frame_cnt == BLINK_LAST);
  assign w_finish    = (w_show_end && (BLINK_TOGGLES == 0)) ||
                       (w_blink_end && (r_blink_cnt == BLINK_END));
  assign w_next_ptr  = (r_grant_id == ID_W'(NUM_TITLES - 1)) ? '0 : r_grant_id + 1'b1;

  // Sequencer FSM: abort beats completion, completion beats normal stepping.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: state registers use non-blocking assignments so every update in
    // this block sees the pre-edge values, independent of statement order.
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_title_en  <= '0;
      r_grant_id  <= '0;
      r_rr_ptr    <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_frame_cnt <= '0;
      r_blink_cnt <= '0;
    end else begin
      r_done <= 1'b0;
      if (bus.force_off) begin
        r_state     <= ST_IDLE;
        r_title_en  <= '0;
        r_busy      <= 1'b0;
        r_frame_cnt <= '0;
        r_blink_cnt <= '0;
      end else if (w_finish) begin
        r_state     <= ST_IDLE;
        r_title_en  <= '0;
        r_busy      <= 1'b0;
        r_done      <= 1'b1;
        r_rr_ptr    <= w_next_ptr;
        r_frame_cnt <= '0;
        r_blink_cnt <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            // frame_start is deliberately ignored here, even in the grant cycle.
            if (w_arb_valid) begin
              r_grant_id <= w_arb_idx;
              r_busy     <= 1'b1;
              r_state    <= ST_ARM;
            end
          end
          ST_ARM: begin
            if (bus.frame_start) begin
              r_title_en  <= w_grant_oh;
              r_frame_cnt <= '0;
              r_state     <= ST_SHOW;
            end
          end
          ST_SHOW: begin
            if (w_show_end) begin
              // Going dark here is the first blink toggle.
              r_title_en  <= '0;
              r_blink_cnt <= BC_W'(1);
              r_frame_cnt <= '0;
              r_state     <= ST_BLINK;
            end else if (bus.frame_start) begin
              r_frame_cnt <= r_frame_cnt + 1'b1;
            end
          end
          ST_BLINK: begin
            if (w_blink_end) begin
              r_frame_cnt <= '0;
              r_title_en  <= r_title_en ^ w_grant_oh;
              r_blink_cnt <= r_blink_cnt + 1'b1;
            end else if (bus.frame_start) begin
              r_frame_cnt <= r_frame_cnt + 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.title_en = r_title_en;
  assign bus.grant_id = r_grant_id;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;

  // Parameter sanity and the zero-or-one-hot enable invariant.
  always_ff @(posedge clk) begin
    if (reset) begin
      assert (BLINK_TOGGLES % 2 == 0);
      assert (SHOW_FRAMES >= 1);
      assert (BLINK_FRAMES >= 1);
      assert ($onehot0(r_title_en));
    end
  end

endmodule

// File: tb/tb_title_sequencer.sv
// Scoreboard bench for title_sequencer: expected per-frame enables and
// per-sequence grant ids are queued with the stimulus and popped as the
// DUTs produce them. A second instance covers the no-blink build.
module tb_title_sequencer;

  localparam int N         = 4;
  localparam int SHOW      = 3;
  localparam int BLINK     = 2;
  localparam int FRAME_LEN = 20;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  title_sequencer_if #(.NUM_TITLES(N)) bus  ();
  title_sequencer_if #(.NUM_TITLES(N)) bus0 ();

  title_sequencer #(
    .NUM_TITLES(N), .SHOW_FRAMES(SHOW), .BLINK_FRAMES(BLINK),
    .BLINK_TOGGLES(4), .CNT_W(8)
  ) dut (.clk(clk), .reset(rst_n), .bus(bus));

  title_sequencer #(
    .NUM_TITLES(N), .SHOW_FRAMES(SHOW), .BLINK_FRAMES(BLINK),
    .BLINK_TOGGLES(0), .CNT_W(8)
  ) dut0 (.clk(clk), .reset(rst_n), .bus(bus0));

  logic [N-1:0] exp_en_q[$];
  logic [N-1:0] exp_en0_q[$];
  logic [1:0]   exp_gnt_q[$];
  logic [1:0]   exp_gnt0_q[$];
  int n_cmp = 0;
  int n_err = 0;

  // Expected mid-frame enables for one full blinking sequence, including
  // the dark frame in which the sequence completes.
  function automatic void push_seq(input logic [N-1:0] oh);
    logic [N-1:0] pat [12];
    pat = '{oh, oh, oh, '0, '0, oh, oh, '0, '0, oh, oh, '0};
    foreach (pat[i]) exp_en_q.push_back(pat[i]);
  endfunction

  // One clock; outputs are sampled 1 time unit after the edge. Done pulses
  // are popped against the expected grant queue of each instance.
  task automatic cyc();
    @(posedge clk);
    #1;
    n_cmp++;
    if (!$onehot0(bus.title_en) || !$onehot0(bus0.title_en)) begin
      n_err++;
      $display("FAIL onehot: title_en=%b title_en0=%b, required zero or one-hot",
               bus.title_en, bus0.title_en);
    end
    if (bus.done === 1'b1) begin
      n_cmp++;
      if (exp_gnt_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_done: done=1 with no sequence outstanding");
      end else begin
        logic [1:0] g;
        g = exp_gnt_q.pop_front();
        if (bus.grant_id !== g || bus.title_en !== '0 || bus.busy !== 1'b0) begin
          n_err++;
          $display("FAIL done_state: grant=%0d en=%b busy=%b, required grant=%0d en=0000 busy=0",
                   bus.grant_id, bus.title_en, bus.busy, g);
        end
      end
    end
    if (bus0.done === 1'b1) begin
      n_cmp++;
      if (exp_gnt0_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_done0: done=1 with no sequence outstanding");
      end else begin
        logic [1:0] g;
        g = exp_gnt0_q.pop_front();
        if (bus0.grant_id !== g || bus0.title_en !== '0 || bus0.busy !== 1'b0) begin
          n_err++;
          $display("FAIL done0_state: grant=%0d en=%b busy=%b, required grant=%0d en=0000 busy=0",
                   bus0.grant_id, bus0.title_en, bus0.busy, g);
        end
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      bus.frame_start  = 1'b0;
      bus0.frame_start = 1'b0;
      cyc();
    end
  endtask

  // nf frames of FRAME_LEN cycles, frame_start on the first cycle; the
  // enables are compared against the queues in the middle of each frame.
  task automatic run_frames(input int nf);
    for (int f = 0; f < nf; f++) begin
      for (int c = 0; c < FRAME_LEN; c++) begin
        bus.frame_start  = (c == 0);
        bus0.frame_start = (c == 0);
        cyc();
        if (c == FRAME_LEN / 2) begin
          if (exp_en_q.size() > 0) begin
            logic [N-1:0] e;
            e = exp_en_q.pop_front();
            n_cmp++;
            if (bus.title_en !== e) begin
              n_err++;
              $display("FAIL frame_en: frame %0d title_en=%b, required %b", f, bus.title_en, e);
            end
          end
          if (exp_en0_q.size() > 0) begin
            logic [N-1:0] e;
            e = exp_en0_q.pop_front();
            n_cmp++;
            if (bus0.title_en !== e) begin
              n_err++;
              $display("FAIL frame_en0: frame %0d title_en=%b, required %b", f, bus0.title_en, e);
            end
          end
        end
      end
    end
    bus.frame_start  = 1'b0;
    bus0.frame_start = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if (bus.title_en !== '0 || bus.grant_id !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: en=%b grant=%0d busy=%b done=%b, required all zero",
               bus.title_en, bus.grant_id, bus.busy, bus.done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(3);
    n_cmp++;
    if (bus.busy !== 1'b0 || bus0.busy !== 1'b0) begin
      n_err++;
      $display("FAIL idle_no_req: busy=%b busy0=%b, required 0", bus.busy, bus0.busy);
    end
  endtask

  task automatic test_reset_mid_blink();
    bus.req = 4'b0001;
    cyc();
    bus.req = '0;
    idle_cycles(2);
    exp_en_q.push_back(4'b0001); exp_en_q.push_back(4'b0001); exp_en_q.push_back(4'b0001);
    exp_en_q.push_back(4'b0000); exp_en_q.push_back(4'b0000); exp_en_q.push_back(4'b0001);
    run_frames(6);
    n_cmp++;
    if (bus.title_en !== 4'b0001) begin
      n_err++;
      $display("FAIL blink_lit: title_en=%b, required 0001", bus.title_en);
    end
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.title_en !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: en=%b busy=%b done=%b, required 0000/0/0",
               bus.title_en, bus.busy, bus.done);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.req = 4'b0001;
    cyc();
    bus.req = '0;
    n_cmp++;
    if (bus.grant_id !== 2'd0 || bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL regrant_after_reset: grant=%0d busy=%b, required 0/1", bus.grant_id, bus.busy);
    end
    push_seq(4'b0001);
    exp_gnt_q.push_back(2'd0);
    idle_cycles(2);
    run_frames(12);
  endtask

  task automatic test_force_off();
    bus.req = 4'b0010;
    cyc();
    n_cmp++;
    if (bus.grant_id !== 2'd1 || bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL grant1: grant=%0d busy=%b, required 1/1", bus.grant_id, bus.busy);
    end
    idle_cycles(2);
    exp_en_q.push_back(4'b0010);
    exp_en_q.push_back(4'b0010);
    run_frames(2);
    idle_cycles(5);
    bus.force_off = 1'b1;
    cyc();
    n_cmp++;
    if (bus.title_en !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL force_off: en=%b busy=%b done=%b, required 0000/0/0",
               bus.title_en, bus.busy, bus.done);
    end
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_cmp++;
      if (bus.busy !== 1'b0 || bus.title_en !== '0) begin
        n_err++;
        $display("FAIL force_off_hold: busy=%b en=%b, required 0/0000", bus.busy, bus.title_en);
      end
    end
    // Both 0 and 1 request: only an unchanged pointer (1) picks title 1.
    bus.req       = 4'b0011;
    bus.force_off = 1'b0;
    cyc();
    bus.req = '0;
    n_cmp++;
    if (bus.grant_id !== 2'd1 || bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL ptr_kept: grant=%0d busy=%b, required 1/1", bus.grant_id, bus.busy);
    end
    push_seq(4'b0010);
    exp_gnt_q.push_back(2'd1);
    idle_cycles(2);
    run_frames(12);
  endtask

  task automatic test_single_pulse();
    bus.req = 4'b0100;
    cyc();
    bus.req = '0;
    n_cmp++;
    if (bus.grant_id !== 2'd2 || bus.busy !== 1'b1 || bus.title_en !== '0) begin
      n_err++;
      $display("FAIL pulse_grant: grant=%0d busy=%b en=%b, required 2/1/0000",
               bus.grant_id, bus.busy, bus.title_en);
    end
    push_seq(4'b0100);
    exp_gnt_q.push_back(2'd2);
    idle_cycles(3);
    run_frames(12);
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.title_en !== '0) begin
      n_err++;
      $display("FAIL pulse_end: busy=%b en=%b, required 0/0000", bus.busy, bus.title_en);
    end
  endtask

  task automatic test_fs_at_grant();
    bus.req          = 4'b1000;
    bus.frame_start  = 1'b1;
    bus0.frame_start = 1'b1;
    cyc();
    bus.req = '0;
    n_cmp++;
    if (bus.grant_id !== 2'd3 || bus.busy !== 1'b1 || bus.title_en !== '0) begin
      n_err++;
      $display("FAIL fs_grant: grant=%0d busy=%b en=%b, required 3/1/0000",
               bus.grant_id, bus.busy, bus.title_en);
    end
    idle_cycles(10);
    n_cmp++;
    if (bus.title_en !== '0) begin
      n_err++;
      $display("FAIL fs_not_counted: title_en=%b, required 0000", bus.title_en);
    end
    idle_cycles(8);
    push_seq(4'b1000);
    exp_gnt_q.push_back(2'd3);
    run_frames(12);
  endtask

  task automatic test_back_to_back();
    bus.req = 4'b1011;
    idle_cycles(2);
    push_seq(4'b0001); exp_gnt_q.push_back(2'd0);
    push_seq(4'b0010); exp_gnt_q.push_back(2'd1);
    push_seq(4'b1000); exp_gnt_q.push_back(2'd3);
    push_seq(4'b0001); exp_gnt_q.push_back(2'd0);
    run_frames(47);
    bus.req = '0;
    run_frames(1);
    idle_cycles(2);
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_end: busy=%b, required 0", bus.busy);
    end
  endtask

  task automatic test_no_blink();
    bus0.req = 4'b0001;
    cyc();
    bus0.req = '0;
    n_cmp++;
    if (bus0.grant_id !== 2'd0 || bus0.busy !== 1'b1) begin
      n_err++;
      $display("FAIL noblink_grant: grant=%0d busy=%b, required 0/1", bus0.grant_id, bus0.busy);
    end
    exp_en0_q.push_back(4'b0001); exp_en0_q.push_back(4'b0001); exp_en0_q.push_back(4'b0001);
    exp_en0_q.push_back(4'b0000); exp_en0_q.push_back(4'b0000);
    exp_gnt0_q.push_back(2'd0);
    idle_cycles(2);
    run_frames(5);
    n_cmp++;
    if (bus0.busy !== 1'b0) begin
      n_err++;
      $display("FAIL noblink_end: busy=%b, required 0", bus0.busy);
    end
  endtask

  task automatic test_drain();
    n_cmp++;
    if (exp_en_q.size() != 0 || exp_en0_q.size() != 0 ||
        exp_gnt_q.size() != 0 || exp_gnt0_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: pending en=%0d en0=%0d done=%0d done0=%0d, required all 0",
               exp_en_q.size(), exp_en0_q.size(), exp_gnt_q.size(), exp_gnt0_q.size());
    end
  endtask

  initial begin
    bus.frame_start  = 1'b0;
    bus.req          = '0;
    bus.force_off    = 1'b0;
    bus0.frame_start = 1'b0;
    bus0.req         = '0;
    bus0.force_off   = 1'b0;
    repeat (3) @(posedge clk);
    test_reset();
    test_reset_mid_blink();
    test_force_off();
    test_single_pulse();
    test_fs_at_grant();
    test_back_to_back();
    test_no_blink();
    test_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
